// File: rtl/csr_exc_commit_pkg.sv
// csr_exc_commit_pkg: shared definitions for the CSR exception/interrupt responder.
//   - CSR numbers for the mapped registers
//   - CRMD field bit positions, reset value and the TLB-refill exception code
//   - csr_merge(): masked read-modify-write helper used by the CSR write port
//   - tmr_state_e: timer FSM states (only used when CSR_TIMER_EN is defined)
package csr_exc_commit_pkg;

  localparam int CSR_ADDR_W = 14;

  localparam logic [13:0] CSR_CRMD      = 14'h0000;
  localparam logic [13:0] CSR_PRMD      = 14'h0001;
  localparam logic [13:0] CSR_ECFG      = 14'h0004;
  localparam logic [13:0] CSR_ESTAT     = 14'h0005;
  localparam logic [13:0] CSR_ERA       = 14'h0006;
  localparam logic [13:0] CSR_BADV      = 14'h0007;
  localparam logic [13:0] CSR_EENTRY    = 14'h000C;
  localparam logic [13:0] CSR_TLBEHI    = 14'h0011;
  localparam logic [13:0] CSR_TID       = 14'h0040;
  localparam logic [13:0] CSR_TCFG      = 14'h0041;
  localparam logic [13:0] CSR_TVAL      = 14'h0042;
  localparam logic [13:0] CSR_TICLR     = 14'h0044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h0088;

  // CRMD layout: [1:0] PLV, [2] IE, [3] DA, [4] PG, [6:5] DATF, [8:7] DATM
  localparam int CRMD_IE = 2;
  localparam int CRMD_DA = 3;
  localparam int CRMD_PG = 4;
  localparam logic [8:0] CRMD_RST = 9'h008;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

  // Masked update: bits under the mask take wdata, the rest keep the old value.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/csr_exc_commit_if.sv
// csr_exc_commit_if: WB-stage <-> CSR commit interface.
//   CSR instruction port : csr_addr, csr_we, csr_wmask, csr_wdata -> csr_rdata
//   Exception commit     : exc_flag, exc_ecode, wen_era/era, wen_badv/badv,
//                          wen_vppn/vppn, tlb_exc, ertn
//   Returns to WB        : cpu_interrupt, eentry, tlbrentry, csr_era
//   modport master = WB stage, modport slave = CSR block.
interface csr_exc_commit_if;
  import csr_exc_commit_pkg::*;

  logic [CSR_ADDR_W-1:0] csr_addr;
  logic                  csr_we;
  logic [31:0]           csr_wmask;
  logic [31:0]           csr_wdata;
  logic [31:0]           csr_rdata;

  logic                  exc_flag;
  logic [6:0]            exc_ecode;
  logic                  wen_era;
  logic [31:0]           era;
  logic                  wen_badv;
  logic [31:0]           badv;
  logic                  wen_vppn;
  logic [18:0]           vppn;
  logic                  tlb_exc;
  logic                  ertn;

  logic                  cpu_interrupt;
  logic [31:0]           eentry;
  logic [31:0]           tlbrentry;
  logic [31:0]           csr_era;

  modport master (
    output csr_addr, csr_we, csr_wmask, csr_wdata,
    output exc_flag, exc_ecode, wen_era, era, wen_badv, badv, wen_vppn, vppn, tlb_exc, ertn,
    input  csr_rdata, cpu_interrupt, eentry, tlbrentry, csr_era
  );

  modport slave (
    input  csr_addr, csr_we, csr_wmask, csr_wdata,
    input  exc_flag, exc_ecode, wen_era, era, wen_badv, badv, wen_vppn, vppn, tlb_exc, ertn,
    output csr_rdata, cpu_interrupt, eentry, tlbrentry, csr_era
  );

endinterface

// File: rtl/csr_exc_commit_timer.sv
// csr_exc_commit_timer: TCFG/TVAL timer with the sticky timer-interrupt bit.
// Only compiled when the CSR_TIMER_EN macro is defined.
// Ports:
//   clk, aresetn  clock, synchronous active-low reset
//   tcfg_we       TCFG write accepted this cycle
//   tcfg_new      merged TCFG value to store
//   ticlr_we      TICLR write with bit0 set (clear timer interrupt)
//   tcfg, tval    current TCFG / TVAL values
//   ti            timer interrupt (ESTAT.IS[11])
// TCFG layout: [0] En, [1] Periodic, [TIMER_W-1:2] InitVal; load value is InitVal<<2.
`ifdef CSR_TIMER_EN
module csr_exc_commit_timer
  import csr_exc_commit_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_new,
  input  logic               ticlr_we,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti
);

  tmr_state_e         state_r, state_nxt;
  logic [TIMER_W-1:0] tcfg_r;
  logic [TIMER_W-1:0] tval_r, tval_nxt;
  logic               ti_r, ti_nxt;
  logic               ti_set_s;

  // Next state: a TCFG write overrides counting; a zero count fires the interrupt.
  always_comb begin
    state_nxt = state_r;
    tval_nxt  = tval_r;
    ti_set_s  = 1'b0;
    if (tcfg_we) begin
      if (tcfg_new[0]) begin
        state_nxt = TMR_RUN;
        tval_nxt  = {tcfg_new[TIMER_W-1:2], 2'b00};
      end else begin
        state_nxt = TMR_IDLE;
      end
    end else begin
      case (state_r)
        TMR_IDLE: state_nxt = TMR_IDLE;
        TMR_RUN: begin
          if (tval_r == {TIMER_W{1'b0}}) begin
            ti_set_s = 1'b1;
            if (tcfg_r[1]) begin
              tval_nxt = {tcfg_r[TIMER_W-1:2], 2'b00};
            end else begin
              state_nxt = TMR_IDLE;
            end
          end else begin
            tval_nxt = tval_r - {{(TIMER_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_nxt = TMR_IDLE;
      endcase
    end
    // A fire in the same cycle as a clear leaves the bit set.
    if (ti_set_s) begin
      ti_nxt = 1'b1;
    end else if (ticlr_we) begin
      ti_nxt = 1'b0;
    end else begin
      ti_nxt = ti_r;
    end
  end

  // Timer state, count, configuration and interrupt registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_r <= TMR_IDLE;
      tcfg_r  <= {TIMER_W{1'b0}};
      tval_r  <= {TIMER_W{1'b0}};
      ti_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      tval_r  <= tval_nxt;
      ti_r    <= ti_nxt;
      if (tcfg_we) begin
        tcfg_r <= tcfg_new;
      end
    end
  end

  assign tcfg = tcfg_r;
  assign tval = tval_r;
  assign ti   = ti_r;

endmodule
`endif

// File: rtl/csr_exc_commit.sv
// csr_exc_commit: CSR-side exception/interrupt responder for the WB commit interface.
// Optional feature macro: CSR_TIMER_EN (TCFG/TVAL/TICLR timer); when undefined the
// timer CSRs read 0, writes to them are ignored and ESTAT.IS[11] stays 0.
// Ports:
//   clk, aresetn          clock, synchronous active-low reset
//   wb (slave)            CSR read/write port, exception/ERTN commit, returns to WB
//   hw_int[7:0], ipi      interrupt lines (level), sampled into ESTAT.IS every cycle
//   crmd_plv/da/pg        current privilege level and translation mode
// Same-cycle priority: exception > ERTN > CSR write (lower ones are dropped).
module csr_exc_commit
  import csr_exc_commit_pkg::*;
#(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  aresetn,
  csr_exc_commit_if.slave       wb,
  input  logic [7:0]            hw_int,
  input  logic                  ipi,
  output logic [1:0]            crmd_plv,
  output logic                  crmd_da,
  output logic                  crmd_pg
);

  // CSR storage holds only implemented bits; reserved bits are rebuilt as 0 on read.
  logic [8:0]  crmd_r;
  logic [2:0]  prmd_r;
  logic [12:0] ecfg_r;
  logic [1:0]  is_sw_r;
  logic [7:0]  is_hw_r;
  logic        ipi_r;
  logic [5:0]  ecode_r;
  logic        esub0_r;
  logic [31:0] era_r;
  logic [31:0] badv_r;
  logic [25:0] eentry_r;
  logic [18:0] tlbehi_r;
  logic [31:0] tid_r;
  logic [25:0] tlbrentry_r;
  logic        cpu_int_r;

  logic [31:0]        rdata_s;
  logic [31:0]        wr_val_s;
  logic               csr_wr_s;
  logic [12:0]        is_vec_s;
  logic               ti_s;
  logic [TIMER_W-1:0] tcfg_s;
  logic [TIMER_W-1:0] tval_s;

  // A CSR instruction write only lands when no exception or ERTN commits.
  assign csr_wr_s = wb.csr_we & ~wb.exc_flag & ~wb.ertn;

`ifdef CSR_TIMER_EN
  logic tcfg_we_s;
  logic ticlr_we_s;

  assign tcfg_we_s  = csr_wr_s & (wb.csr_addr == CSR_TCFG);
  assign ticlr_we_s = csr_wr_s & (wb.csr_addr == CSR_TICLR) & wr_val_s[0];

  csr_exc_commit_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .aresetn  (aresetn),
    .tcfg_we  (tcfg_we_s),
    .tcfg_new (wr_val_s[TIMER_W-1:0]),
    .ticlr_we (ticlr_we_s),
    .tcfg     (tcfg_s),
    .tval     (tval_s),
    .ti       (ti_s)
  );
`else
  assign tcfg_s = {TIMER_W{1'b0}};
  assign tval_s = {TIMER_W{1'b0}};
  assign ti_s   = 1'b0;
`endif

  // Read mux; its value doubles as the old value for the masked write merge.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (wb.csr_addr)
      CSR_CRMD:      rdata_s = {23'h000000, crmd_r};
      CSR_PRMD:      rdata_s = {29'h00000000, prmd_r};
      CSR_ECFG:      rdata_s = {19'h00000, ecfg_r};
      CSR_ESTAT:     rdata_s = {1'b0, 8'h00, esub0_r, ecode_r, 3'b000,
                                ipi_r, ti_s, 1'b0, is_hw_r, is_sw_r};
      CSR_ERA:       rdata_s = era_r;
      CSR_BADV:      rdata_s = badv_r;
      CSR_EENTRY:    rdata_s = {eentry_r, 6'h00};
      CSR_TLBEHI:    rdata_s = {tlbehi_r, 13'h0000};
      CSR_TID:       rdata_s = tid_r;
      CSR_TCFG:      rdata_s = 32'(tcfg_s);
      CSR_TVAL:      rdata_s = 32'(tval_s);
      CSR_TLBRENTRY: rdata_s = {tlbrentry_r, 6'h00};
      default:       rdata_s = 32'h0000_0000;
    endcase
  end

  assign wr_val_s = csr_merge(rdata_s, wb.csr_wdata, wb.csr_wmask);

  // CSR state: interrupt sampling every cycle, then exception > ERTN > CSR write.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      crmd_r      <= CRMD_RST;
      prmd_r      <= 3'b000;
      ecfg_r      <= 13'h0000;
      is_sw_r     <= 2'b00;
      is_hw_r     <= 8'h00;
      ipi_r       <= 1'b0;
      ecode_r     <= 6'h00;
      esub0_r     <= 1'b0;
      era_r       <= 32'h0000_0000;
      badv_r      <= 32'h0000_0000;
      eentry_r    <= 26'h0000000;
      tlbehi_r    <= 19'h00000;
      tid_r       <= TID_RST;
      tlbrentry_r <= 26'h0000000;
    end else begin
      is_hw_r <= hw_int;
      ipi_r   <= ipi;
      if (wb.exc_flag) begin
        prmd_r           <= {crmd_r[CRMD_IE], crmd_r[1:0]};
        crmd_r[1:0]      <= 2'b00;
        crmd_r[CRMD_IE]  <= 1'b0;
        ecode_r          <= wb.exc_ecode[5:0];
        esub0_r          <= wb.exc_ecode[6];
        if (wb.tlb_exc) begin
          crmd_r[CRMD_DA] <= 1'b1;
          crmd_r[CRMD_PG] <= 1'b0;
        end
        if (wb.wen_era) begin
          era_r <= wb.era;
        end
        if (wb.wen_badv) begin
          badv_r <= wb.badv;
        end
        if (wb.wen_vppn) begin
          tlbehi_r <= wb.vppn;
        end
      end else if (wb.ertn) begin
        crmd_r[1:0]     <= prmd_r[1:0];
        crmd_r[CRMD_IE] <= prmd_r[2];
        // Returning from a TLB refill re-enables paging.
        if (ecode_r == ECODE_TLBR) begin
          crmd_r[CRMD_DA] <= 1'b0;
          crmd_r[CRMD_PG] <= 1'b1;
        end
      end else if (csr_wr_s) begin
        case (wb.csr_addr)
          CSR_CRMD:      crmd_r      <= wr_val_s[8:0];
          CSR_PRMD:      prmd_r      <= wr_val_s[2:0];
          CSR_ECFG:      ecfg_r      <= wr_val_s[12:0];
          CSR_ESTAT:     is_sw_r     <= wr_val_s[1:0];
          CSR_ERA:       era_r       <= wr_val_s;
          CSR_BADV:      badv_r      <= wr_val_s;
          CSR_EENTRY:    eentry_r    <= wr_val_s[31:6];
          CSR_TLBEHI:    tlbehi_r    <= wr_val_s[31:13];
          CSR_TID:       tid_r       <= wr_val_s;
          CSR_TLBRENTRY: tlbrentry_r <= wr_val_s[31:6];
          default:       ;
        endcase
      end
    end
  end

  assign is_vec_s = {ipi_r, ti_s, 1'b0, is_hw_r, is_sw_r};

  // Registered interrupt request from the current CSR state.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cpu_int_r <= 1'b0;
    end else begin
      cpu_int_r <= crmd_r[CRMD_IE] & (|(is_vec_s & ecfg_r));
    end
  end

  assign wb.csr_rdata     = rdata_s;
  assign wb.cpu_interrupt = cpu_int_r;
  assign wb.eentry        = {eentry_r, 6'h00};
  assign wb.tlbrentry     = {tlbrentry_r, 6'h00};
  assign wb.csr_era       = era_r;
  assign crmd_plv         = crmd_r[1:0];
  assign crmd_da          = crmd_r[CRMD_DA];
  assign crmd_pg          = crmd_r[CRMD_PG];

endmodule
